// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and opcode helpers for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_RVEC,
        S_RUN,
        S_IVEC
    } fetch_state_t;

    localparam logic [7:0] NOP_INSTR = 8'h00;
    localparam logic [3:0] LONG_OPC  = 4'hC;

    function automatic logic is_long(input logic [7:0] instr);
        return instr[7:4] == LONG_OPC;
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: PC, reset/interrupt vector sequencing and 1/2-byte instruction sizing for the IF stage.
// Interrupt entry (irq_pend, S_IVEC, IRQ_VEC) exists only when FETCH_IRQ_EN is defined.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [7:0] RST_VEC = 8'h00,
    parameter logic [7:0] IRQ_VEC = 8'h01
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       stall,
    input  logic       branch_taken,
    input  logic [7:0] branch_target,
    input  logic       interrupt,
    output logic [7:0] imem_addr0,
    input  logic [7:0] imem_data0,
    output logic [7:0] imem_addr1,
    input  logic [7:0] imem_data1,
    output logic [7:0] pc_plus1_if,
    output logic [7:0] instr_if,
    output logic [7:0] imm_if,
    output logic       interrupt_if
);

    fetch_state_t state_q, state_d;
    logic [7:0]   pc_q, pc_d;
    logic         irq_pend_q, irq_pend_d;
    logic         run, long_instr, take_irq;
    logic [7:0]   pc_seq;

    assign run        = state_q == S_RUN;
    assign long_instr = is_long(imem_data0);
    assign pc_seq     = pc_q + (long_instr ? 8'd2 : 8'd1);

`ifdef FETCH_IRQ_EN
    // The marker only goes out on a cycle that would otherwise advance the PC.
    assign take_irq   = run && irq_pend_q && !branch_taken && !stall;
    assign imem_addr0 = state_q == S_RVEC ? RST_VEC : state_q == S_IVEC ? IRQ_VEC : pc_q;
`else
    logic [8:0] unused_irq;
    assign unused_irq = {interrupt, IRQ_VEC};
    assign take_irq   = 1'b0;
    assign imem_addr0 = run ? pc_q : RST_VEC;
`endif

    assign imem_addr1   = pc_q + 8'd1;
    assign instr_if     = (run && !branch_taken && !take_irq) ? imem_data0 : NOP_INSTR;
    assign imm_if       = (run && !take_irq && long_instr) ? imem_data1 : 8'h00;
    assign pc_plus1_if  = (run && !take_irq) ? pc_seq : pc_q;
    assign interrupt_if = take_irq;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        irq_pend_d = irq_pend_q;
        case (state_q)
            S_RVEC: begin
                pc_d    = imem_data0;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (branch_taken) begin
                    pc_d = branch_target;
                end else if (take_irq) begin
                    irq_pend_d = 1'b0;
                    state_d    = S_IVEC;
                end else if (!stall) begin
                    pc_d = pc_seq;
                end
            end
`ifdef FETCH_IRQ_EN
            S_IVEC: begin
                // A redirect aborts the vector fetch; the request is retried later.
                state_d    = S_RUN;
                pc_d       = branch_taken ? branch_target : imem_data0;
                irq_pend_d = irq_pend_q | branch_taken;
            end
`endif
            default: state_d = S_RVEC;
        endcase
`ifdef FETCH_IRQ_EN
        irq_pend_d = irq_pend_d | interrupt;
`else
        irq_pend_d = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_RVEC;
            pc_q       <= 8'h00;
            irq_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            irq_pend_q <= irq_pend_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed literal checks plus randomized traffic against a behavioural fetch model.
// Honours FETCH_IRQ_EN the same way the design does.
module tb_fetch_unit;

`ifdef FETCH_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, stall, branch_taken, interrupt;
    logic [7:0] branch_target;
    logic [7:0] imem_addr0, imem_data0, imem_addr1, imem_data1;
    logic [7:0] pc_plus1_if, instr_if, imm_if;
    logic       interrupt_if;
    logic [7:0] mem [256];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign imem_data0 = mem[imem_addr0];
    assign imem_data1 = mem[imem_addr1];

    fetch_unit dut (
        .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .interrupt(interrupt),
        .imem_addr0(imem_addr0), .imem_data0(imem_data0),
        .imem_addr1(imem_addr1), .imem_data1(imem_data1),
        .pc_plus1_if(pc_plus1_if), .instr_if(instr_if), .imm_if(imm_if),
        .interrupt_if(interrupt_if)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Model: mode 0 = fetching reset vector, 1 = running, 2 = fetching interrupt vector.
    int         m_mode = 0;
    logic [7:0] m_pc = 8'h00;
    bit         m_pend = 1'b0;
    bit         m_ok = 1'b0;

    always @(posedge clk) begin
        int         nm;
        logic [7:0] np, ins, len;
        bit         npd;
        nm  = m_mode;
        np  = m_pc;
        npd = m_pend;
        ins = mem[m_pc];
        len = (ins[7:4] == 4'hC) ? 8'd2 : 8'd1;
        if (rst) begin
            nm = 0; np = 8'h00; npd = 1'b0;
        end else begin
            if (m_mode == 0) begin
                np = mem[8'h00]; nm = 1;
            end else if (m_mode == 2) begin
                nm = 1;
                if (branch_taken) begin np = branch_target; npd = 1'b1; end
                else np = mem[8'h01];
            end else if (branch_taken) np = branch_target;
            else if (stall) np = m_pc;
            else if (IRQ_EN && m_pend) begin npd = 1'b0; nm = 2; end
            else np = m_pc + len;
            if (IRQ_EN && interrupt) npd = 1'b1;
        end
        m_mode <= nm;
        m_pc   <= np;
        m_pend <= npd;
        m_ok   <= m_ok | rst;
    end

    always @(negedge clk) begin
        logic [7:0] e_a0, e_ins, e_imm, e_pp, ins;
        logic       e_int;
        if (m_ok) begin
            ins   = mem[m_pc];
            e_a0  = m_mode == 0 ? 8'h00 : m_mode == 2 ? 8'h01 : m_pc;
            e_ins = 8'h00; e_imm = 8'h00; e_pp = m_pc; e_int = 1'b0;
            if (m_mode == 1) begin
                if (!branch_taken && !stall && IRQ_EN && m_pend) e_int = 1'b1;
                else begin
                    e_ins = branch_taken ? 8'h00 : ins;
                    e_imm = (ins[7:4] == 4'hC) ? mem[m_pc + 8'd1] : 8'h00;
                    e_pp  = m_pc + ((ins[7:4] == 4'hC) ? 8'd2 : 8'd1);
                end
                chk("addr1", imem_addr1, m_pc + 8'd1);
            end
            chk("addr0", imem_addr0, e_a0);
            chk("instr", instr_if, e_ins);
            chk("imm", imm_if, e_imm);
            chk("pc_plus1", pc_plus1_if, e_pp);
            chk("irq_flag", {7'd0, interrupt_if}, {7'd0, e_int});
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic peek();
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[8'h00] = 8'h10; mem[8'h01] = 8'h80;
        mem[8'h10] = 8'h21; mem[8'h11] = 8'hC3; mem[8'h12] = 8'h5A; mem[8'h13] = 8'h07;
        mem[8'hFF] = 8'hC7; mem[8'h20] = 8'h21; mem[8'h30] = 8'h05;
        mem[8'h40] = 8'h01; mem[8'h44] = 8'h22; mem[8'h80] = 8'h66;
        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 8'h00; interrupt = 1'b0;
        tick(); tick();
        rst = 1'b0;
        peek();
        chk("rvec_instr", instr_if, 8'h00); chk("rvec_addr0", imem_addr0, 8'h00);
        chk("rvec_pcp1", pc_plus1_if, 8'h00);
        tick(); peek();
        chk("boot_addr0", imem_addr0, 8'h10); chk("boot_instr", instr_if, 8'h21);
        chk("boot_pcp1", pc_plus1_if, 8'h11); chk("boot_imm", imm_if, 8'h00);
        tick(); peek();
        chk("long_instr", instr_if, 8'hC3); chk("long_imm", imm_if, 8'h5A);
        chk("long_pcp1", pc_plus1_if, 8'h13); chk("long_addr1", imem_addr1, 8'h12);
        tick(); peek();
        chk("after_long", imem_addr0, 8'h13);
        branch_taken = 1'b1; branch_target = 8'hFF; peek();
        chk("br_kill", instr_if, 8'h00);
        tick(); branch_taken = 1'b0; peek();
        chk("wrap_addr1", imem_addr1, 8'h00); chk("wrap_instr", instr_if, 8'hC7);
        chk("wrap_imm", imm_if, 8'h10); chk("wrap_pcp1", pc_plus1_if, 8'h01);
        mem[8'hFF] = 8'h33; branch_taken = 1'b1;
        tick(); branch_taken = 1'b0; peek();
        chk("wrap_short", instr_if, 8'h33); chk("wrap_spcp1", pc_plus1_if, 8'h00);
        tick(); peek();
        chk("wrap_pc", imem_addr0, 8'h00); chk("wrap_pc_ins", instr_if, 8'h10);
        branch_taken = 1'b1; branch_target = 8'h20;
        tick(); branch_taken = 1'b0; stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); peek();
            chk("stall_pc", imem_addr0, 8'h20); chk("stall_ins", instr_if, 8'h21);
        end
        stall = 1'b0;
        tick(); peek();
        chk("unstall_pc", imem_addr0, 8'h21);
        branch_taken = 1'b1; branch_target = 8'h30; interrupt = 1'b1;
        tick(); branch_taken = 1'b0; interrupt = 1'b0; peek();
        if (IRQ_EN) begin
            chk("mark_flag", {7'd0, interrupt_if}, 8'h01); chk("mark_ins", instr_if, 8'h00);
            chk("mark_pcp1", pc_plus1_if, 8'h30); chk("mark_imm", imm_if, 8'h00);
            tick(); peek();
            chk("ivec_addr0", imem_addr0, 8'h01); chk("ivec_ins", instr_if, 8'h00);
            tick(); peek();
            chk("isr_addr0", imem_addr0, 8'h80); chk("isr_ins", instr_if, 8'h66);
        end else begin
            chk("noirq_flag", {7'd0, interrupt_if}, 8'h00); chk("noirq_ins", instr_if, 8'h05);
            chk("noirq_pcp1", pc_plus1_if, 8'h31);
        end
        branch_taken = 1'b1; branch_target = 8'h40;
        tick(); branch_taken = 1'b0; stall = 1'b1; interrupt = 1'b1;
        tick(); interrupt = 1'b0; peek();
        chk("stall_over_irq", {7'd0, interrupt_if}, 8'h00); chk("stall_irq_pc", imem_addr0, 8'h40);
        branch_taken = 1'b1; branch_target = 8'h44; peek();
        chk("br_all_ins", instr_if, 8'h00); chk("br_all_flag", {7'd0, interrupt_if}, 8'h00);
        tick(); branch_taken = 1'b0; stall = 1'b0; peek();
        chk("br_all_pc", imem_addr0, 8'h44);
        chk("pend_kept", {7'd0, interrupt_if}, IRQ_EN ? 8'h01 : 8'h00);
        chk("pend_pcp1", pc_plus1_if, IRQ_EN ? 8'h44 : 8'h45);
        for (int i = 0; i < 4000; i++) begin
            tick();
            rst           = $urandom_range(0, 199) == 0;
            stall         = $urandom_range(0, 3) == 0;
            branch_taken  = $urandom_range(0, 7) == 0;
            branch_target = 8'($urandom);
            interrupt     = $urandom_range(0, 15) == 0;
        end
        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
